fpu_arbiter: RTL and testbench

- Shares one FPU instance between NUM_REQ requesters using round-robin arbitration.
- Sequences each operation:
  - latches the winner's operands;
  - restarts the FPU through its active-low reset;
  - waits a fixed latency;
  - captures data_out/status_out and returns them to the winner with a valid/ready handshake.
- Sits between the requesting units and FPU (clock, reset, op_A_in, op_B_in, data_out, status_out).
- Operand format: 1 sign, 6-bit exponent (bias 31), 25-bit mantissa.

---
 rtl/fpu_arbiter.sv | 145 ++++++++++++++
 tb/tb_fpu_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter that time-shares one FPU between NUM_REQ requesters.
// Optional FPU_ARB_PERF_EN adds saturating per-requester completion counters (perf_cnt).
//
// state | meaning
// IDLE  | FPU held in reset, round-robin pick offered on req_ready
// START | operands registered, FPU held in reset for one cycle
// RUN   | FPU released, latency down-counter running
// RESP  | captured result presented to the granted requester
module fpu_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int FPU_LATENCY = 8,
    parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_op_a,
    input  logic [NUM_REQ*32-1:0]  req_op_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [31:0]            rsp_data,
    output logic [3:0]             rsp_status,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
`ifdef FPU_ARB_PERF_EN
    output logic [NUM_REQ*16-1:0]  perf_cnt,
`endif
    output logic                   fpu_rst_n,
    output logic [31:0]            fpu_op_a,
    output logic [31:0]            fpu_op_b,
    input  logic [31:0]            fpu_data,
    input  logic [3:0]             fpu_status
);

    localparam int CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic              handshake;
    logic              accept;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        handshake = 1'b0;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    handshake = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (cnt == '0)
                    state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready[grant_id]) begin
                    accept  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gating with reset keeps req_ready at its reset value while reset is held.
    assign req_ready = (state_q == S_IDLE && found && !reset) ? (NUM_REQ'(1) << winner) : '0;
    assign rsp_valid = (state_q == S_RESP) ? (NUM_REQ'(1) << grant_id) : '0;
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            cnt        <= '0;
            fpu_rst_n  <= 1'b0;
            fpu_op_a   <= '0;
            fpu_op_b   <= '0;
            rsp_data   <= '0;
            rsp_status <= '0;
        end else begin
            state_q   <= state_d;
            // Registered so the FPU reset line is glitch-free; high exactly in RUN.
            fpu_rst_n <= (state_d == S_RUN);
            if (handshake) begin
                fpu_op_a <= req_op_a[32*int'(winner) +: 32];
                fpu_op_b <= req_op_b[32*int'(winner) +: 32];
                grant_id <= winner;
            end
            if (state_q == S_START)
                cnt <= CNT_W'(FPU_LATENCY - 1);
            else if (state_q == S_RUN && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state_q == S_RUN && cnt == '0) begin
                rsp_data   <= fpu_data;
                rsp_status <= fpu_status;
            end
            if (accept)
                rr_ptr <= ID_W'((int'(grant_id) + 1) % NUM_REQ);
        end
    end

`ifdef FPU_ARB_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && grant_id == ID_W'(i) && perf_cnt[16*i +: 16] != 16'hFFFF)
                    perf_cnt[16*i +: 16] <= perf_cnt[16*i +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a behavioural latency-accurate FPU model.
// Perf-counter checks are included when FPU_ARB_PERF_EN is defined.
module tb_fpu_arbiter;

    localparam int N = 2;
    localparam int L = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_op_a = '0;
    logic [N*32-1:0] req_op_b = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [31:0]     rsp_data;
    logic [3:0]      rsp_status;
    logic            busy;
    logic [0:0]      grant_id;
    logic            fpu_rst_n;
    logic [31:0]     fpu_op_a, fpu_op_b, fpu_data;
    logic [3:0]      fpu_status;
`ifdef FPU_ARB_PERF_EN
    logic [N*16-1:0] perf_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fpu_arbiter #(.NUM_REQ(N), .FPU_LATENCY(L)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .busy(busy), .grant_id(grant_id),
`ifdef FPU_ARB_PERF_EN
        .perf_cnt(perf_cnt),
`endif
        .fpu_rst_n(fpu_rst_n), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
        .fpu_data(fpu_data), .fpu_status(fpu_status)
    );

    always #5 clock = ~clock;

    // FPU model: result only becomes valid L cycles after reset release.
    logic [3:0] fcnt;
    always_ff @(posedge clock or negedge fpu_rst_n) begin
        if (!fpu_rst_n)
            fcnt <= '0;
        else if (fcnt != 4'hF)
            fcnt <= fcnt + 4'd1;
    end

    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'hBE000000_BE000000: return 32'hC0000000;
            64'h40000000_C2000000: return 32'hC0000000;
            64'h3F000000_3C000000: return 32'h40000000;
            64'h3E000000_BE000000: return 32'h00000000;
            default:               return a ^ b;
        endcase
    endfunction

    function automatic logic [3:0] fpu_st(input logic [31:0] r);
        if (r == 32'h0) return 4'b0001;
        if (r[31])      return 4'b0010;
        return 4'b0000;
    endfunction

    logic fpu_ok;
    assign fpu_ok     = fpu_rst_n && (fcnt >= 4'(L - 1));
    assign fpu_data   = fpu_ok ? fpu_fn(fpu_op_a, fpu_op_b) : 32'hDEADBEEF;
    assign fpu_status = fpu_ok ? fpu_st(fpu_fn(fpu_op_a, fpu_op_b)) : 4'hF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] onehot(input int g);
        return 32'(1) << g;
    endfunction

    // Called just after a negedge with the DUT in IDLE; returns just after the
    // negedge following the response accept (DUT back in IDLE).
    task automatic do_op(input logic [1:0] mask,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input int eg, input logic [31:0] ed, input logic [3:0] es,
                         input int hold, input bit keep);
        int  n;
        int  hi;
        bit  got;
        logic [31:0] ea, eb;
        ea = (eg == 1) ? a1 : a0;
        eb = (eg == 1) ? b1 : b0;
        req_valid = mask;
        req_op_a  = {a1, a0};
        req_op_b  = {b1, b0};
        rsp_ready = '0;
        #1;
        check("req_ready_onehot", 32'(req_ready), onehot(eg));
        @(posedge clock);
        n = 0; hi = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clock);
            n++;
            if (!keep) req_valid = '0;
            if (n == 1) begin
                check("start_fpu_rst_n", 32'(fpu_rst_n), 32'd0);
                check("start_busy", 32'(busy), 32'd1);
                check("grant_id", 32'(grant_id), 32'(eg));
                check("fpu_op_a", fpu_op_a, ea);
                check("fpu_op_b", fpu_op_b, eb);
            end
            if (fpu_rst_n) hi++;
            if (rsp_valid != '0) got = 1'b1;
        end
        check("rsp_latency", 32'(n), 32'(L + 2));
        check("fpu_run_cycles", 32'(hi), 32'(L));
        check("rsp_valid", 32'(rsp_valid), onehot(eg));
        check("rsp_data", rsp_data, ed);
        check("rsp_status", 32'(rsp_status), 32'(es));
        for (int h = 0; h < hold; h++) begin
            req_valid = 2'b11;
            rsp_ready = 2'b11 ^ (2'b01 << eg);
            @(negedge clock);
            check("bp_rsp_valid", 32'(rsp_valid), onehot(eg));
            check("bp_rsp_data", rsp_data, ed);
            check("bp_rsp_status", 32'(rsp_status), 32'(es));
            check("bp_no_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready = 2'b01 << eg;
        req_valid = keep ? mask : 2'b00;
        @(negedge clock);
        rsp_ready = '0;
        check("accept_busy", 32'(busy), 32'd0);
        check("accept_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] a0, b0, a1, b1;
        int          eg;
        logic [31:0] ed;
        logic [3:0]  es;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit saw_rsp;
        vecs[0] = '{2'b11, 32'h40000000, 32'hC2000000, 32'h3F000000, 32'h3C000000, 0, 32'hC0000000, 4'b0010};
        vecs[1] = '{2'b11, 32'h40000000, 32'hC2000000, 32'h3F000000, 32'h3C000000, 1, 32'h40000000, 4'b0000};
        vecs[2] = '{2'b10, 32'h12345678, 32'h9ABCDEF0, 32'h3E000000, 32'hBE000000, 1, 32'h00000000, 4'b0001};
        vecs[3] = '{2'b01, 32'hBE000000, 32'hBE000000, 32'h11111111, 32'h22222222, 0, 32'hC0000000, 4'b0010};
        vecs[4] = '{2'b01, 32'h40000000, 32'hC2000000, 32'h33333333, 32'h44444444, 0, 32'hC0000000, 4'b0010};
        vecs[5] = '{2'b11, 32'h40000000, 32'hC2000000, 32'h3F000000, 32'h3C000000, 1, 32'h40000000, 4'b0000};

        // Reset values, with requests pending to show req_ready is held low.
        req_valid = 2'b11;
        req_op_a  = {32'h3F000000, 32'h40000000};
        req_op_b  = {32'h3C000000, 32'hC2000000};
        repeat (2) @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_fpu_rst_n", 32'(fpu_rst_n), 32'd0);
        check("rst_fpu_op_a", fpu_op_a, 32'd0);
        check("rst_fpu_op_b", fpu_op_b, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_status", 32'(rsp_status), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = '0;
        reset = 1'b0;
        @(negedge clock);

        // Single request from requester 0: -1.0 + -1.0.
        do_op(2'b01, 32'hBE000000, 32'hBE000000, 32'h0, 32'h0, 0, 32'hC0000000, 4'b0010, 0, 1'b0);

        apply_reset();
        for (int i = 0; i < 6; i++)
            do_op(vecs[i].mask, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                  vecs[i].eg, vecs[i].ed, vecs[i].es, 0, 1'b0);

        // Continuous requests from both: grants alternate, one IDLE cycle between ops.
        for (int k = 0; k < 4; k++)
            do_op(2'b11, 32'h40000000, 32'hC2000000, 32'h3F000000, 32'h3C000000,
                  k % 2, (k % 2 == 1) ? 32'h40000000 : 32'hC0000000,
                  (k % 2 == 1) ? 4'b0000 : 4'b0010, 0, (k != 3));

        // Backpressure on requester 1 for 20 cycles.
        do_op(2'b10, 32'h55555555, 32'h66666666, 32'h3E000000, 32'hBE000000, 1, 32'h00000000, 4'b0001, 20, 1'b0);

        // Abort in RUN: rr_ptr moves to 1 first, reset must bring it back to 0.
        do_op(2'b01, 32'hBE000000, 32'hBE000000, 32'h0, 32'h0, 0, 32'hC0000000, 4'b0010, 0, 1'b0);
        req_valid = 2'b10;
        req_op_a  = {32'h3E000000, 32'h0};
        req_op_b  = {32'hBE000000, 32'h0};
        @(posedge clock);
        repeat (4) @(negedge clock);
        check("run_fpu_rst_n", 32'(fpu_rst_n), 32'd1);
        check("run_grant_id", 32'(grant_id), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_fpu_rst_n", 32'(fpu_rst_n), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_grant_id", 32'(grant_id), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        req_valid = '0;
        saw_rsp = 1'b0;
        repeat (15) begin
            @(negedge clock);
            if (rsp_valid != '0) saw_rsp = 1'b1;
        end
        check("abort_no_rsp", 32'(saw_rsp), 32'd0);
        do_op(2'b11, 32'h40000000, 32'hC2000000, 32'h3F000000, 32'h3C000000, 0, 32'hC0000000, 4'b0010, 0, 1'b0);

`ifdef FPU_ARB_PERF_EN
        apply_reset();
        check("perf_rst", perf_cnt, 32'd0);
        do_op(2'b01, 32'hBE000000, 32'hBE000000, 32'h0, 32'h0, 0, 32'hC0000000, 4'b0010, 0, 1'b0);
        for (int k = 0; k < 3; k++)
            do_op(2'b10, 32'h0, 32'h0, 32'h3F000000, 32'h3C000000, 1, 32'h40000000, 4'b0000, 0, 1'b0);
        check("perf_req0", 32'(perf_cnt[0 +: 16]), 32'd1);
        check("perf_req1", 32'(perf_cnt[16 +: 16]), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
